// File: rtl/cu_seq_pkg.sv
// Shared opcode, state and flag definitions for the cu_seq control unit.
// Flag layout is {carry, negative, zero}; see CU_SEQ_FLAGS_EN in cu_seq.sv.
package cu_seq_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_NOT = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 2;

    function automatic logic [2:0] pack_flags(input logic c, input logic n, input logic z);
        logic [2:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/cu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// o_done/o_prod are valid combinationally during the final iteration cycle.
module cu_seq_mul
    import cu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_prod
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;

    // Multiplicand shifts left while the multiplier shifts right, so bit 0 is always bit i.
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_prod = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cu_seq.sv
// Handshaked control unit: single-cycle ALU ops plus iterative MUL, result held until consumed.
// Define CU_SEQ_FLAGS_EN to build the {carry, negative, zero} flag logic; otherwise flags read 0.
module cu_seq
    import cu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flags
);

    localparam int unsigned MUL_LAT_CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_alu_res;
    logic [WIDTH-1:0]     r_result;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_start   = w_accept && (op == OP_MUL);
    assign result    = r_result;

    cu_seq_mul #(
        .WIDTH (WIDTH),
        .CNT_W (MUL_LAT_CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_a     (operand1),
        .i_b     (operand2),
        .o_done  (w_mul_done),
        .o_prod  (w_prod)
    );

    // Single-cycle ops are evaluated on the accept edge, so the result lands with DONE.
    always_comb begin
        w_alu_res = '0;
        case (op)
            OP_ADD:  w_alu_res = operand1 + operand2;
            OP_SUB:  w_alu_res = operand1 - operand2;
            OP_AND:  w_alu_res = operand1 & operand2;
            OP_OR:   w_alu_res = operand1 | operand2;
            OP_XOR:  w_alu_res = operand1 ^ operand2;
            OP_NOT:  w_alu_res = ~operand1;
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (op == OP_MUL) ? MUL : DONE;
                end
            end
            MUL: begin
                if (w_mul_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_result <= w_alu_res;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_result <= w_prod[WIDTH-1:0];
        end
    end

`ifdef CU_SEQ_FLAGS_EN
    logic       w_carry;
    logic [2:0] r_flags;

    // ADD wrapped iff the truncated sum is below an addend; SUB borrows iff a < b.
    always_comb begin
        w_carry = 1'b0;
        case (op)
            OP_ADD:  w_carry = (w_alu_res < operand1);
            OP_SUB:  w_carry = (operand1 < operand2);
            default: w_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_accept && (op != OP_MUL)) begin
            r_flags <= pack_flags(w_carry, w_alu_res[WIDTH-1], (w_alu_res == '0));
        end else if ((r_state == MUL) && w_mul_done) begin
            r_flags <= pack_flags(|w_prod[2*WIDTH-1:WIDTH], w_prod[WIDTH-1],
                                  (w_prod[WIDTH-1:0] == '0));
        end
    end

    assign flags = r_flags;
`else
    assign flags = '0;
`endif

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq (WIDTH=8 and WIDTH=16) with a queue scoreboard of model results.
// Expected flags follow CU_SEQ_FLAGS_EN exactly as the DUT build does.
module tb_cu_seq;

`ifdef CU_SEQ_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [2:0]  op8, flags8;
    logic [7:0]  a8, b8, result8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [2:0]  op16, flags16;
    logic [15:0] a16, b16, result16;

    exp_t        sb[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    cu_seq #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .op        (op8),
        .operand1  (a8),
        .operand2  (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .result    (result8),
        .flags     (flags8)
    );

    cu_seq #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .op        (op16),
        .operand1  (a16),
        .operand2  (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .result    (result16),
        .flags     (flags16)
    );

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int unsigned w);
        logic [63:0] mask, aa, bb, full, r;
        logic        c;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = {32'd0, b} & mask;
        c    = 1'b0;
        r    = 64'd0;
        full = 64'd0;
        case (o)
            3'd1: begin full = aa + bb; r = full & mask; c = ((full >> w) != 64'd0); end
            3'd2: begin r = (aa - bb) & mask; c = (aa < bb); end
            3'd3: r = aa & bb;
            3'd4: r = aa | bb;
            3'd5: r = aa ^ bb;
            3'd6: r = (~aa) & mask;
            3'd7: begin full = aa * bb; r = full & mask; c = ((full >> w) != 64'd0); end
            default: r = 64'd0;
        endcase
        e.res = r[31:0];
        e.flg = FLAGS_ON ? {c, (((r >> (w - 1)) & 64'd1) != 64'd0), (r == 64'd0)} : 3'b000;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input bit push);
        int unsigned k;
        op8 = o; a8 = a; b8 = b; in_valid8 = 1'b1;
        if (push) sb.push_back(model(o, {24'd0, a}, {24'd0, b}, 8));
        k = 0;
        while (!in_ready8 && k < 20) begin
            step();
            k++;
        end
        if (!in_ready8) check("accept_timeout", 32'(in_ready8), 32'd1);
        step();
        in_valid8 = 1'b0;
        op8 = 3'($urandom_range(0, 7));
        a8  = 8'($urandom);
        b8  = 8'($urandom);
    endtask

    task automatic get8(input string tag, input int unsigned lat, input int unsigned hold);
        int unsigned n;
        bit          ir_hi, stable;
        exp_t        e;
        n     = 1;
        ir_hi = in_ready8;
        while (!out_valid8 && n < 40) begin
            step();
            n++;
            if (in_ready8) ir_hi = 1'b1;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy_irdy"}, 32'(ir_hi), 32'd0);
        e = sb.pop_front();
        check({tag, "_res"}, 32'(result8), e.res);
        check({tag, "_flg"}, 32'(flags8), 32'(e.flg));
        stable = 1'b1;
        repeat (hold) begin
            step();
            if (result8 !== e.res[7:0] || flags8 !== e.flg || in_ready8 !== 1'b0 ||
                out_valid8 !== 1'b1) stable = 1'b0;
        end
        check({tag, "_hold"}, 32'(stable), 32'd1);
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        check({tag, "_idle"}, 32'(in_ready8), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e16;
        logic [2:0] ro;
        rst = 1'b1;
        in_valid8 = 1'b0; out_ready8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
        step();
        step();
        rst = 1'b0;

        check("rst_in_ready", 32'(in_ready8), 32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_result", 32'(result8), 32'd0);
        check("rst_flags", 32'(flags8), 32'd0);

        // out_ready with nothing pending must not disturb IDLE
        out_ready8 = 1'b1;
        step();
        out_ready8 = 1'b0;
        check("idle_ordy_valid", 32'(out_valid8), 32'd0);
        check("idle_ordy_ready", 32'(in_ready8), 32'd1);

        send8(3'd1, 8'hF0, 8'h20, 1'b1);
        get8("add_ovf", 1, 0);
        check("add_ovf_const", 32'(result8), 32'h10);

        send8(3'd2, 8'h05, 8'h07, 1'b1);
        get8("sub_borrow", 1, 0);
        send8(3'd2, 8'h07, 8'h07, 1'b1);
        get8("sub_zero", 1, 0);

        send8(3'd7, 8'h0C, 8'h0B, 1'b1);
        get8("mul_0c0b", 9, 0);
        send8(3'd7, 8'h10, 8'h10, 1'b1);
        get8("mul_ovf", 9, 0);

        send8(3'd5, 8'hAA, 8'hFF, 1'b1);
        get8("xor_bp", 1, 5);
        send8(3'd4, 8'h0F, 8'h30, 1'b1);
        get8("or_after_bp", 1, 0);

        send8(3'd7, 8'h03, 8'h05, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midmul_out_valid", 32'(out_valid8), 32'd0);
        check("midmul_in_ready", 32'(in_ready8), 32'd1);
        check("midmul_result", 32'(result8), 32'd0);
        check("midmul_flags", 32'(flags8), 32'd0);

        send8(3'd6, 8'h0F, 8'h00, 1'b1);
        get8("not_after_rst", 1, 0);
        check("not_const", 32'(result8), 32'hF0);

        send8(3'd0, 8'h12, 8'h34, 1'b1);
        get8("nop", 1, 0);
        send8(3'd3, 8'hC3, 8'h5A, 1'b1);
        get8("and", 1, 0);
        send8(3'd7, 8'hFF, 8'hFF, 1'b1);
        get8("mul_max", 9, 0);

        for (int i = 0; i < 10; i++) begin
            ro = 3'($urandom_range(0, 7));
            send8(ro, 8'($urandom), 8'($urandom), 1'b1);
            get8("rnd", (ro == 3'd7) ? 9 : 1, 0);
        end

        // 16-bit instance: carry out of the top bit with a zero result
        e16 = model(3'd1, 32'h0000_FFFF, 32'h0000_0001, 16);
        check("w16_idle", 32'(in_ready16), 32'd1);
        op16 = 3'd1; a16 = 16'hFFFF; b16 = 16'h0001; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0; a16 = 16'h1234; b16 = 16'h5678;
        check("w16_valid", 32'(out_valid16), 32'd1);
        check("w16_res", 32'(result16), e16.res);
        check("w16_flg", 32'(flags16), 32'(e16.flg));
        out_ready16 = 1'b1;
        step();
        out_ready16 = 1'b0;
        check("w16_release", 32'(in_ready16), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
